// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the immediate/data extension unit.
//   MODE_W   : width of the extension mode field
//   mode_t   : extension mode type
//   EXT_*    : extension mode encodings
package ext_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t EXT_ZERO   = 3'd0;
  localparam mode_t EXT_SIGN   = 3'd1;
  localparam mode_t EXT_HIGH   = 3'd2;
  localparam mode_t EXT_BRANCH = 3'd3;
  localparam mode_t EXT_LB     = 3'd4;
  localparam mode_t EXT_LBU    = 3'd5;
  localparam mode_t EXT_LH     = 3'd6;
  localparam mode_t EXT_LHU    = 3'd7;

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational operand extension.
// Optional build macro: EXT_LOADEXT_EN makes modes 4-7 (LB/LBU/LH/LHU) legal;
// without it those modes report illegal and produce zero.
// Ports:
//   in_data  [IN_W]   raw operand
//   in_mode  [MODE_W] extension mode
//   ext_data [OUT_W]  extended result (0 when the mode is illegal)
//   illegal  [1]      mode not supported in this build
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  ext_data,
  output logic              illegal
);

  logic signed [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    ext_data = '0;
    illegal  = 1'b0;
    case (in_mode)
      EXT_ZERO:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      EXT_SIGN:   ext_data = sext;
      EXT_HIGH:   ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      // Branch offset: word offset turned into a byte offset.
      EXT_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
`ifdef EXT_LOADEXT_EN
      EXT_LB:     ext_data = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
      EXT_LBU:    ext_data = {{(OUT_W-8){1'b0}}, in_data[7:0]};
      EXT_LH:     ext_data = {{(OUT_W-16){in_data[15]}}, in_data[15:0]};
      EXT_LHU:    ext_data = {{(OUT_W-16){1'b0}}, in_data[15:0]};
`endif
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: buffered extension unit for the decode/execute boundary.
// Extends each accepted operand via ext_core and queues the result in a
// DEPTH-entry FIFO; results leave in order over a valid/ready handshake.
// Optional build macro: EXT_LOADEXT_EN (load-data modes 4-7, see ext_core).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               drop all queued entries and this cycle's input
//   in_valid/in_ready   input handshake (in_ready = room in the FIFO)
//   in_data, in_mode    operand and extension mode
//   out_valid/out_ready output handshake for the head entry
//   out_data            head entry, 0 while empty
//   count               occupancy
//   err_mode            sticky: an illegal mode was accepted
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [MODE_W-1:0]          in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_mode
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [OUT_W-1:0] ext_data_p0;
  logic             illegal_p0;
  logic [OUT_W-1:0] fifo_p1 [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data_p0),
    .illegal  (illegal_p0)
  );

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Stage p0 -> p1: extended value captured into the FIFO on acceptance.
  always_ff @(posedge clk) begin
    if (accept) fifo_p1[wr_ptr] <= ext_data_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_mode <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && illegal_p0) err_mode <= 1'b1;
    end
  end

  // Stage p1 output: head entry, forced to 0 while empty.
  assign out_data = out_valid ? fifo_p1[rd_ptr] : '0;

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed plus randomized checking of ext_pipe against a
// queue-based reference model computed from the extension rules.
module tb_ext_pipe;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;
  logic        err_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  logic        m_err;

  ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .err_mode  (err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_illegal(input logic [2:0] m);
`ifdef EXT_LOADEXT_EN
    return 1'b0;
`else
    return (m >= 3'd4);
`endif
  endfunction

  // Extension rules expressed as integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [2:0] m);
    longint u  = longint'(d);
    longint s  = (u >= 32768) ? u - 65536 : u;
    longint b  = u % 256;
    longint sb = (b >= 128) ? b - 256 : b;
    if (ref_illegal(m)) return 32'd0;
    case (m)
      3'd0:    return 32'(u);
      3'd1:    return 32'(s);
      3'd2:    return 32'(u * 65536);
      3'd3:    return 32'(s * 4);
      3'd4:    return 32'(sb);
      3'd5:    return 32'(b);
      3'd6:    return 32'(s);
      default: return 32'(u);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count",     32'(count),     32'(q.size()));
    chk("out_data",  out_data,       (q.size() != 0) ? q[0] : 32'd0);
    chk("err_mode",  32'(err_mode),  32'(m_err));
  endtask

  // One clock: drive at the falling edge, check, update model on the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [2:0] m,
                      input logic ordy, input logic fl);
    logic acc, pp;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; flush = fl;
    #1;
    check_model();
    acc = v && (q.size() < DEPTH) && !fl;
    pp  = ordy && (q.size() != 0) && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_ext(d, m));
        if (ref_illegal(m)) m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_model();
    reset = 1'b0;
    @(negedge clk);

    // Four basic modes back to back with immediate drain.
    step(1'b1, 16'h8001, 3'd0, 1'b1, 1'b0); chk("zero",   out_data, 32'h00008001);
    step(1'b1, 16'h8001, 3'd1, 1'b1, 1'b0); chk("sign",   out_data, 32'hFFFF8001);
    step(1'b1, 16'h8001, 3'd2, 1'b1, 1'b0); chk("high",   out_data, 32'h80010000);
    step(1'b1, 16'h8001, 3'd3, 1'b1, 1'b0); chk("branch", out_data, 32'hFFFE0004);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);

    // Backpressure: fill, refuse a third, drain in order.
    step(1'b1, 16'h0001, 3'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 3'd0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h0003, 3'd0, 1'b0, 1'b0);
    chk("full_hold", out_data, 32'd1);
    step(1'b1, 16'h0003, 3'd0, 1'b1, 1'b0);
    chk("drain1", out_data, 32'd2);
    chk("drain1_cnt", 32'(count), 32'd1);
    step(1'b1, 16'h0003, 3'd0, 1'b1, 1'b0);
    chk("drain2", out_data, 32'd3);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);

    // Flush drops queued data and the value offered alongside it.
    step(1'b1, 16'h0005, 3'd0, 1'b0, 1'b0);
    step(1'b1, 16'h7FFF, 3'd0, 1'b0, 1'b1);
    chk("flush_cnt",   32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data",  out_data, 32'd0);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);

`ifdef EXT_LOADEXT_EN
    step(1'b1, 16'h0080, 3'd4, 1'b1, 1'b0); chk("lb",  out_data, 32'hFFFFFF80);
    step(1'b1, 16'h0080, 3'd5, 1'b1, 1'b0); chk("lbu", out_data, 32'h00000080);
    step(1'b1, 16'h8000, 3'd6, 1'b1, 1'b0); chk("lh",  out_data, 32'hFFFF8000);
    step(1'b1, 16'h8000, 3'd7, 1'b1, 1'b0); chk("lhu", out_data, 32'h00008000);
    chk("load_err", 32'(err_mode), 32'd0);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);
`else
    step(1'b1, 16'h0080, 3'd4, 1'b1, 1'b0);
    chk("illegal_data", out_data, 32'd0);
    chk("illegal_err",  32'(err_mode), 32'd1);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b1);
    chk("err_sticky", 32'(err_mode), 32'd1);
`endif

    // Asynchronous reset in the middle of a full queue.
    step(1'b1, 16'h0011, 3'd5, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 3'd1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_err",   32'(err_mode), 32'd0);
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 16'h1234, 3'd1, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  out_data, 32'h00001234);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 16'($urandom), 3'($urandom_range(7)),
           1'($urandom_range(1)), ($urandom_range(15) == 0));
    end
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 3'd0, 1'b1, 1'b0);
    #1 check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, buffered immediate/data extension unit for the decode/execute boundary of the pipelined MIPS core.
- Accepts narrow values with an extension mode over a valid/ready handshake.
- Computes the OUT_W-bit extended result on acceptance and queues it in a DEPTH-entry FIFO.
- Presents results in order downstream; supports pipeline flush and an illegal-mode sticky flag.

Parameters:
- IN_W, 16, input operand width; must be ≥ 16.
- OUT_W, 32, output width; must be ≥ IN_W+2.
- DEPTH, 2, FIFO entries; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued entries and any input offered this cycle
- in_valid  input  1  producer offers in_data/in_mode
- in_ready  output  1  unit can accept this cycle
- in_data  input  IN_W  raw operand
- in_mode  input  3  extension mode
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head this cycle
- out_data  output  OUT_W  extended head value
- count  output  $clog2(DEPTH+1)  current occupancy
- err_mode  output  1  sticky: an illegal mode was accepted

Behaviour:
- Reset (async, active-high): FIFO empty, count=0, out_valid=0, out_data=0, err_mode=0, pointers=0; in_ready=1 after reset deasserts.
- Accept: accept = in_valid & in_ready & ~flush. Pop: pop = out_valid & out_ready & ~flush.
- Ready rule: in_ready = (count < DEPTH).
  - No same-cycle pass-through when full; a pop while full frees a slot only for the next cycle.
  - in_ready does not depend on out_ready.
- Latency: a value accepted into an empty FIFO appears on out_data with out_valid=1 the next cycle.
- Ordering: strict FIFO order.
- Simultaneous accept and pop (count between 1 and DEPTH-1): count unchanged.
- Pointers wrap modulo DEPTH.
- out_data: equals the head entry while out_valid=1; holds 0 when empty.
- Flush:
  - Takes priority over accept and pop.
  - Next cycle: count=0, out_valid=0, out_data=0.
  - Input offered during flush is dropped; err_mode is unaffected.
- Modes (result computed combinationally at input, stored registered):
  - 0 ZERO: zero-extend in_data.
  - 1 SIGN: sign-extend from bit IN_W-1.
  - 2 HIGH: in_data placed in the top IN_W bits, low OUT_W-IN_W bits zero (LUI).
  - 3 BRANCH: sign-extend, then shift left 2 (branch offset).
  - 4-7: see Optional Feature. When illegal, the value stored is 0 and err_mode sets on acceptance.
- err_mode: sticky until reset; flush does not clear it.
- Reset mid-operation: all state returns to reset values immediately, regardless of handshake state.

Optional Feature:
- Macro: EXT_LOADEXT_EN
- Defined — load-data extension modes are legal:
  - 4 LB: sign-extend in_data[7:0].
  - 5 LBU: zero-extend in_data[7:0].
  - 6 LH: sign-extend in_data[15:0].
  - 7 LHU: zero-extend in_data[15:0].
- Undefined: modes 4-7 are illegal; they store 0 and set err_mode.

Decomposition:
- Shared package ext_pkg:
  - Mode localparams EXT_ZERO=0, EXT_SIGN=1, EXT_HIGH=2, EXT_BRANCH=3, EXT_LB=4, EXT_LBU=5, EXT_LH=6, EXT_LHU=7.
  - Mode field width 3.
- One natural sub-module, ext_core: purely combinational (in_data, in_mode) → (ext_data, illegal).
- ext_pipe wraps ext_core with the FIFO, handshake and flush logic.

Test Plan:
- Defaults; accept in_data=16'h8001 with modes 0,1,2,3 in consecutive cycles, out_ready=1 → out_data sequence 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each one cycle after its accept.
- out_ready=0; push 16'h0001, 16'h0002 → count=2, in_ready=0; third offer 16'h0003 is not accepted. Set out_ready=1 → outputs 1 then 2; 3 is accepted the cycle after in_ready returns and appears afterwards.
- Fill to count=1, then flush=1 while in_valid=1 with 16'h7FFF → next cycle count=0, out_valid=0; 16'h7FFF never appears on out_data.
- Without EXT_LOADEXT_EN: accept mode=4, in_data=16'h0080 → out_data=0, err_mode=1; err_mode stays 1 after a later flush.
- With EXT_LOADEXT_EN: in_data=16'h0080 modes 4,5 → 32'hFFFFFF80, 32'h00000080, err_mode=0. in_data=16'h8000 modes 6,7 → 32'hFFFF8000, 32'h00008000.
- Assert reset mid-stream with count=2 → out_valid, count, out_data, err_mode go to 0 asynchronously; first accept after release appears one cycle later.
